// File: rtl/tdm_demux_pkg.sv
// Shared types and default sizes for the TDM 1:8 demultiplexer.
// Optional ERR_CNT output is enabled with TDM_DEMUX_ERR_CNT_EN.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_LANES = 8;
  localparam int SLOT_W    = $clog2(DEF_LANES);
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index register: clear, load-to-1, or increment with natural wrap.
// Controls are one-hot or all idle; the top guarantees exclusivity.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load1,
  input  logic                     inc,
  output logic [$clog2(LANES)-1:0] slot
);

  localparam int SW = $clog2(LANES);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    unique case (1'b1)
      clr:     slot_d = '0;
      load1:   slot_d = SW'(1);
      inc:     slot_d = slot_q + SW'(1);
      default: slot_d = slot_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux1to8.sv
// TDM 1:LANES demultiplexer: rebuilds parallel lanes from a SYNC-marked stream.
// Define TDM_DEMUX_ERR_CNT_EN to add a saturating ERR_CNT output.
module tdm_demux1to8
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         D,
  input  logic                     D_VALID,
  input  logic                     SYNC,
  output logic [LANES*WIDTH-1:0]   Y,
  output logic                     Y_VALID,
  output logic [$clog2(LANES)-1:0] SLOT,
  output logic                     ERR
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     ERR_CNT
`endif
);

  localparam int SW = $clog2(LANES);
  localparam logic [SW-1:0] LAST = SW'(LANES - 1);

  tdm_state_e state_q, state_d;

  logic [WIDTH-1:0]       shadow_q [LANES];
  logic [WIDTH-1:0]       shadow_d [LANES];
  logic [LANES*WIDTH-1:0] y_q, y_d;
  logic                   yv_q, yv_d;
  logic                   err_q, err_d;
  logic                   s_clr, s_load, s_inc;
  logic [SW-1:0]          slot;

  tdm_slot_counter #(
    .LANES(LANES)
  ) u_slot (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (s_clr),
    .load1(s_load),
    .inc  (s_inc),
    .slot (slot)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    yv_d     = 1'b0;
    err_d    = 1'b0;
    s_clr    = 1'b0;
    s_load   = 1'b0;
    s_inc    = 1'b0;
    if (D_VALID) begin
      unique case (state_q)
        HUNT: begin
          if (SYNC) begin
            shadow_d[0] = D;
            s_load      = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            SYNC: begin
              // Early SYNC restarts the frame at lane 0
              shadow_d[0] = D;
              s_load      = 1'b1;
              err_d       = (slot != '0);
            end
            (!SYNC && slot == '0): begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
            (!SYNC && slot == LAST): begin
              for (int k = 0; k < LANES - 1; k++)
                y_d[k*WIDTH +: WIDTH] = shadow_q[k];
              y_d[(LANES-1)*WIDTH +: WIDTH] = D;
              yv_d  = 1'b1;
              s_clr = 1'b1;
            end
            default: begin
              shadow_d[slot] = D;
              s_inc          = 1'b1;
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      for (int k = 0; k < LANES; k++) shadow_q[k] <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      yv_q     <= yv_d;
      err_q    <= err_d;
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ERR_CNT = cnt_q;
`endif

  assign Y       = y_q;
  assign Y_VALID = yv_q;
  assign ERR     = err_q;
  assign SLOT    = slot;

endmodule

// File: tb/tb_tdm_demux1to8.sv
// Randomized and directed bench for tdm_demux1to8 against a frame-level model.
// Define TDM_DEMUX_ERR_CNT_EN to also check ERR_CNT.
module tb_tdm_demux1to8;

  localparam int W = 1;
  localparam int L = 8;
  localparam int SW = $clog2(L);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  dd = '0;
  logic          dv = 1'b0;
  logic          sy = 1'b0;
  logic [L*W-1:0] y;
  logic          yv;
  logic [SW-1:0] slot;
  logic          err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  tdm_demux1to8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .D      (dd),
    .D_VALID(dv),
    .SYNC   (sy),
    .Y      (y),
    .Y_VALID(yv),
    .SLOT   (slot),
    .ERR    (err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .ERR_CNT(err_cnt)
`endif
  );

  // Frame-level model: a queue of samples collected since lane 0
  bit           aligned = 0;
  logic [W-1:0] q[$];
  logic [L*W-1:0] e_y = '0;
  bit           e_yv = 0;
  bit           e_err = 0;
  int           e_cnt = 0;

  always @(posedge clk) begin
    e_yv  = 0;
    e_err = 0;
    if (!rst_n) begin
      aligned = 0;
      q.delete();
      e_y   = '0;
      e_cnt = 0;
    end else if (dv) begin
      if (!aligned) begin
        if (sy) begin
          q = {dd};
          aligned = 1;
        end
      end else if (sy) begin
        if (q.size() != 0) e_err = 1;
        q = {dd};
      end else if (q.size() == 0) begin
        e_err = 1;
        aligned = 0;
      end else begin
        q.push_back(dd);
        if (q.size() == L) begin
          for (int k = 0; k < L; k++) e_y[k*W +: W] = q[k];
          e_yv = 1;
          q.delete();
        end
      end
      if (e_err && e_cnt < 255) e_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y", 32'(y), 32'(e_y));
      chk("y_valid", 32'(yv), 32'(e_yv));
      chk("err", 32'(err), 32'(e_err));
      chk("slot", 32'(slot), 32'(q.size()));
`ifdef TDM_DEMUX_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
`endif
    end
  end

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    dv = v;
    sy = s;
    dd = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Sample taken by the next edge; look at registered result just after it
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [L-1:0] f, input int gap);
    for (int k = 0; k < L; k++) begin
      step(1'b1, k == 0, f[k]);
      if (k != L - 1) idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    dv = 1'b1;
    sy = 1'b1;
    dd = '1;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    dv = 1'b0;
    sy = 1'b0;
  endtask

  initial begin
    // 1: reset with D_VALID held high
    rst_n = 1'b0;
    dv = 1'b1;
    sy = 1'b1;
    dd = '1;
    @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    rst_n = 1'b1;
    dv = 1'b0;
    sy = 1'b0;

    // 2: back-to-back frame 1,0,0,0,0,0,0,1
    send_frame(8'b1000_0001, 0);
    after_edge();
    chk("f2_y", 32'(y), 32'h81);
    chk("f2_yv", 32'(yv), 32'h1);
    chk("f2_slot", 32'(slot), 32'h0);
    idle(1);
    after_edge();
    chk("f2_yv_off", 32'(yv), 32'h0);
    chk("f2_y_hold", 32'(y), 32'h81);

    // 3: same frame with 3-cycle gaps, different value to see the update
    send_frame(8'b0101_1010, 3);
    after_edge();
    chk("f3_y", 32'(y), 32'h5A);
    chk("f3_yv", 32'(yv), 32'h1);
    idle(2);

    // 4: early SYNC on 5th sample
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    after_edge();
    chk("f4_err", 32'(err), 32'h1);
    chk("f4_slot", 32'(slot), 32'h1);
    for (int k = 1; k < L; k++) step(1'b1, 1'b0, W'(k & 1));
    after_edge();
    chk("f4_y", 32'(y), 32'hAA);
    chk("f4_yv", 32'(yv), 32'h1);

    // 5: missing SYNC after a good frame
    step(1'b1, 1'b0, 1'b1);
    after_edge();
    chk("f5_err", 32'(err), 32'h1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1);
    after_edge();
    chk("f5_hunt_err", 32'(err), 32'h0);
    chk("f5_hunt_slot", 32'(slot), 32'h0);
    send_frame(8'b1100_0011, 1);
    after_edge();
    chk("f5_y", 32'(y), 32'hC3);

    // 6: reset at SLOT=4
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b1);
    after_edge();
    chk("f6_slot4", 32'(slot), 32'h4);
    do_reset(1);
    chk("f6_y", 32'(y), 32'h0);
    chk("f6_slot", 32'(slot), 32'h0);
    send_frame(8'b0000_1111, 0);
    after_edge();
    chk("f6_after_y", 32'(y), 32'h0F);

`ifdef TDM_DEMUX_ERR_CNT_EN
    // Continuous SYNC: every sample after the first is an early-sync error
    for (int k = 0; k < 261; k++) step(1'b1, 1'b1, 1'b0);
    after_edge();
    chk("cnt_sat", 32'(err_cnt), 32'hFF);
    do_reset(1);
    chk("cnt_clr", 32'(err_cnt), 32'h0);
`endif

    // Random: mix of well-formed frames with gaps and raw noise
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [L-1:0] f;
        f = L'($urandom);
        for (int k = 0; k < L; k++) begin
          step(1'b1, k == 0, f[k]);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end else begin
        for (int k = 0; k < 10; k++)
          step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
               W'($urandom));
      end
      if ($urandom_range(0, 60) == 0) do_reset(1);
    end
    idle(3);
    @(negedge clk);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
